// File: rtl/pkt_nib_tx_if.sv
// Frame-request and nibble-stream bundle for pkt_nib_tx.
// master = traffic controller (drives header fields), slave = the serializer.
interface pkt_nib_tx_if #(
    parameter int PAY_W = 8
);
    logic             start;
    logic             vlan_en;
    logic [15:0]      vlan_tci;
    logic [47:0]      Dstmac;
    logic [47:0]      Srcmac;
    logic [15:0]      Ethproto;
    logic [7:0]       Ipproto;
    logic [31:0]      srcip4;
    logic [31:0]      dstip4;
    logic [15:0]      Srcport;
    logic [15:0]      Dstport;
    logic [15:0]      icmp;
    logic [PAY_W-1:0] pay_len;
    logic [3:0]       d;
    logic             strobe;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, vlan_en, vlan_tci, Dstmac, Srcmac, Ethproto, Ipproto,
               srcip4, dstip4, Srcport, Dstport, icmp, pay_len,
        input  d, strobe, valid, busy, done
    );

    modport slave (
        input  start, vlan_en, vlan_tci, Dstmac, Srcmac, Ethproto, Ipproto,
               srcip4, dstip4, Srcport, Dstport, icmp, pay_len,
        output d, strobe, valid, busy, done
    );
endinterface

// File: rtl/pkt_nib_tx.sv
// Nibble-serial Ethernet/IPv4 frame generator, MS nibble first, strobe on nibble 0.
// Define PKT_TX_CSUM_EN to fill in the IPv4 header checksum; otherwise it is sent as 0000.
module pkt_nib_tx #(
    parameter int         PAY_W = 8,
    parameter int         IFG   = 4,
    parameter logic [7:0] TTL   = 8'h40
) (
    input logic         clk,
    input logic         reset,
    pkt_nib_tx_if.slave bus
);
    localparam int CW = (PAY_W > 6) ? PAY_W : 6;
    localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ETH, S_IP, S_L4, S_PAY, S_GAP} state_t;

    state_t           r_state;
    logic             r_vlanEn;
    logic [15:0]      r_vlanTci;
    logic [47:0]      r_dstMac;
    logic [47:0]      r_srcMac;
    logic [15:0]      r_ethProto;
    logic [7:0]       r_ipProto;
    logic [31:0]      r_srcIp;
    logic [31:0]      r_dstIp;
    logic [15:0]      r_srcPort;
    logic [15:0]      r_dstPort;
    logic [15:0]      r_icmp;
    logic [PAY_W-1:0] r_payLen;
    logic [143:0]     r_shEth;
    logic [159:0]     r_shIp;
    logic [31:0]      r_shL4;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_payIdx;
    logic [GW-1:0]    r_gap;
    logic [3:0]       r_d;
    logic             r_strobe;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_ipEn;
    logic [3:0]       w_l4Len;
    logic [PAY_W-1:0] w_payLen;
    logic             w_payNz;
    logic [5:0]       w_ethLen;
    logic [15:0]      w_totalLen;
    logic [15:0]      w_csum;
    logic [143:0]     w_eth;
    logic [159:0]     w_ip;
    logic [31:0]      w_l4;
    state_t           w_nextSec;
    logic             w_lastSec;

    assign w_ipEn     = (r_ethProto == 16'h0800);
    assign w_payLen   = r_payLen & ~PAY_W'(1);
    assign w_payNz    = (w_payLen != '0);
    assign w_ethLen   = r_vlanEn ? 6'd36 : 6'd28;
    assign w_totalLen = 16'd20 + 16'(w_l4Len >> 1) + 16'(w_payLen >> 1);

    // L4 header exists only inside an IPv4 frame, and only for TCP/UDP/ICMP
    always_comb begin
        w_l4Len = 4'd0;
        if (w_ipEn) begin
            if (r_ipProto == 8'h06 || r_ipProto == 8'h11) begin
                w_l4Len = 4'd8;
            end else if (r_ipProto == 8'h01) begin
                w_l4Len = 4'd4;
            end
        end
    end

`ifdef PKT_TX_CSUM_EN
    logic [19:0] w_sum;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;

    assign w_sum   = 20'(16'h4500) + 20'(w_totalLen) + 20'(16'h4000) + 20'({TTL, r_ipProto})
                   + 20'(r_srcIp[31:16]) + 20'(r_srcIp[15:0])
                   + 20'(r_dstIp[31:16]) + 20'(r_dstIp[15:0]);
    assign w_fold1 = 17'(w_sum[15:0]) + 17'(w_sum[19:16]);
    assign w_fold2 = w_fold1[15:0] + 16'(w_fold1[16]);
    assign w_csum  = ~w_fold2;
`else
    assign w_csum = 16'h0000;
`endif

    assign w_eth = r_vlanEn ? {r_dstMac, r_srcMac, 16'h8100, r_vlanTci, r_ethProto}
                            : {r_dstMac, r_srcMac, r_ethProto, 32'h0};
    assign w_ip  = {16'h4500, w_totalLen, 16'h0000, 16'h4000, TTL, r_ipProto,
                    w_csum, r_srcIp, r_dstIp};
    assign w_l4  = (r_ipProto == 8'h01) ? {r_icmp, 16'h0} : {r_srcPort, r_dstPort};

    // Skip empty sections; GAP as the successor means this section ends the frame
    always_comb begin
        w_nextSec = S_GAP;
        case (r_state)
            S_ETH:   w_nextSec = w_ipEn ? S_IP : (w_payNz ? S_PAY : S_GAP);
            S_IP:    w_nextSec = (w_l4Len != 4'd0) ? S_L4 : (w_payNz ? S_PAY : S_GAP);
            S_L4:    w_nextSec = w_payNz ? S_PAY : S_GAP;
            default: w_nextSec = S_GAP;
        endcase
    end

    assign w_lastSec = (w_nextSec == S_GAP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_vlanEn   <= 1'b0;
            r_vlanTci  <= '0;
            r_dstMac   <= '0;
            r_srcMac   <= '0;
            r_ethProto <= '0;
            r_ipProto  <= '0;
            r_srcIp    <= '0;
            r_dstIp    <= '0;
            r_srcPort  <= '0;
            r_dstPort  <= '0;
            r_icmp     <= '0;
            r_payLen   <= '0;
            r_shEth    <= '0;
            r_shIp     <= '0;
            r_shL4     <= '0;
            r_cnt      <= '0;
            r_payIdx   <= '0;
            r_gap      <= '0;
            r_d        <= '0;
            r_strobe   <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_d     <= '0;
                    r_valid <= 1'b0;
                    if (bus.start) begin
                        r_vlanEn   <= bus.vlan_en;
                        r_vlanTci  <= bus.vlan_tci;
                        r_dstMac   <= bus.Dstmac;
                        r_srcMac   <= bus.Srcmac;
                        r_ethProto <= bus.Ethproto;
                        r_ipProto  <= bus.Ipproto;
                        r_srcIp    <= bus.srcip4;
                        r_dstIp    <= bus.dstip4;
                        r_srcPort  <= bus.Srcport;
                        r_dstPort  <= bus.Dstport;
                        r_icmp     <= bus.icmp;
                        r_payLen   <= bus.pay_len;
                        r_busy     <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Nibble 0 leaves here, so the Ethernet shifter is loaded already advanced
                    r_shEth  <= w_eth << 4;
                    r_shIp   <= w_ip;
                    r_shL4   <= w_l4;
                    r_d      <= w_eth[143:140];
                    r_valid  <= 1'b1;
                    r_strobe <= 1'b1;
                    r_cnt    <= CW'(w_ethLen) - CW'(1);
                    r_state  <= S_ETH;
                end
                S_ETH, S_IP, S_L4, S_PAY: begin
                    if (r_cnt != '0) begin
                        r_cnt  <= r_cnt - CW'(1);
                        r_done <= (r_cnt == CW'(1)) && w_lastSec;
                        case (r_state)
                            S_ETH: begin
                                r_d     <= r_shEth[143:140];
                                r_shEth <= r_shEth << 4;
                            end
                            S_IP: begin
                                r_d    <= r_shIp[159:156];
                                r_shIp <= r_shIp << 4;
                            end
                            S_L4: begin
                                r_d    <= r_shL4[31:28];
                                r_shL4 <= r_shL4 << 4;
                            end
                            default: begin
                                r_d      <= r_payIdx;
                                r_payIdx <= r_payIdx + 4'd1;
                            end
                        endcase
                    end else begin
                        r_state <= w_nextSec;
                        case (w_nextSec)
                            S_IP: begin
                                r_d    <= r_shIp[159:156];
                                r_shIp <= r_shIp << 4;
                                r_cnt  <= CW'(39);
                            end
                            S_L4: begin
                                r_d    <= r_shL4[31:28];
                                r_shL4 <= r_shL4 << 4;
                                r_cnt  <= CW'(w_l4Len) - CW'(1);
                            end
                            S_PAY: begin
                                r_d      <= 4'd0;
                                r_payIdx <= 4'd1;
                                r_cnt    <= CW'(w_payLen) - CW'(1);
                            end
                            default: begin
                                r_d     <= 4'd0;
                                r_valid <= 1'b0;
                                r_gap   <= GW'(IFG - 1);
                            end
                        endcase
                    end
                end
                S_GAP: begin
                    r_d     <= '0;
                    r_valid <= 1'b0;
                    if (r_gap == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_d     <= '0;
                end
            endcase
        end
    end

    assign bus.d      = r_d;
    assign bus.strobe = r_strobe;
    assign bus.valid  = r_valid;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule
